// File: rtl/ppu_bg_fetcher.sv
// rtl/ppu_bg_fetcher.sv - BG/window tile fetcher feeding the PPU BG pixel FIFO during mode 3
// Optional fine-scroll discard of the first BG burst is enabled with PPU_BG_FINE_SCROLL_EN.
module ppu_bg_fetcher #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic        line_end,
    input  logic        win_start,
    input  logic        obj_stall,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  win_line,
    input  logic        bg_map_sel,
    input  logic        win_map_sel,
    input  logic        tile_data_sel,
    output logic        vram_req,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_rdata,
    input  logic [4:0]  fifo_count,
    output logic        fifo_push,
    output logic [1:0]  fifo_color,
    output logic        fifo_flush,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, TILE_REQ, TILE_CAP, LO_REQ, LO_CAP, HI_REQ, HI_CAP, PUSH_WAIT, PUSH
    } state_t;

    state_t      state;
    logic [4:0]  fetch_x;
    logic        win_mode;
    logic [7:0]  tile_no;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [2:0]  pix;
    logic        cap_done;
    logic [7:0]  bg_y;
    logic        can_push;
    logic        keep;

    assign bg_y     = scy + ly;
    assign can_push = (int'(fifo_count) <= FIFO_DEPTH - 8) && !obj_stall;

`ifdef PPU_BG_FINE_SCROLL_EN
    logic       first_burst;
    logic [2:0] emit_idx;
    assign emit_idx = (state == PUSH) ? pix : 3'd0;
    assign keep     = !(first_burst && !win_mode && (emit_idx < scx[2:0]));
`else
    logic unused_fine_scroll;
    assign unused_fine_scroll = ^scx[2:0];
    assign keep = 1'b1;
`endif

    function automatic logic [12:0] map_addr(input logic win, input logic [4:0] fx);
        logic [4:0] col;
        logic [4:0] row;
        logic       sel;
        col = win ? fx : (scx[7:3] + fx);
        row = win ? win_line[7:3] : bg_y[7:3];
        sel = win ? win_map_sel : bg_map_sel;
        return {2'b11, sel, row, col};
    endfunction

    function automatic logic [12:0] data_addr(input logic [7:0] tile);
        logic [2:0] r;
        r = win_mode ? win_line[2:0] : bg_y[2:0];
        if (tile_data_sel)
            return {1'b0, tile, r, 1'b0};
        return 13'h1000 + {tile[7], tile, 4'b0000} + {9'd0, r, 1'b0};
    endfunction

    function automatic logic [1:0] color_of(input logic [7:0] h, input logic [7:0] l,
                                            input logic [2:0] k);
        return {h[3'd7 - k], l[3'd7 - k]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_x    <= 5'd0;
            win_mode   <= 1'b0;
            tile_no    <= 8'd0;
            lo         <= 8'd0;
            hi         <= 8'd0;
            pix        <= 3'd0;
            cap_done   <= 1'b0;
            vram_req   <= 1'b0;
            vram_addr  <= 13'd0;
            fifo_push  <= 1'b0;
            fifo_color <= 2'd0;
            fifo_flush <= 1'b0;
            busy       <= 1'b0;
`ifdef PPU_BG_FINE_SCROLL_EN
            first_burst <= 1'b0;
`endif
        end else begin
            fifo_flush <= 1'b0;
            fifo_push  <= 1'b0;
            fifo_color <= 2'd0;
            vram_req   <= 1'b0;
            if (line_start) begin
                state      <= TILE_REQ;
                fetch_x    <= 5'd0;
                win_mode   <= 1'b0;
                pix        <= 3'd0;
                cap_done   <= 1'b0;
                fifo_flush <= 1'b1;
                vram_req   <= 1'b1;
                vram_addr  <= map_addr(1'b0, 5'd0);
                busy       <= 1'b1;
`ifdef PPU_BG_FINE_SCROLL_EN
                first_burst <= 1'b1;
`endif
            end else if (win_start && state != IDLE) begin
                state      <= TILE_REQ;
                fetch_x    <= 5'd0;
                win_mode   <= 1'b1;
                pix        <= 3'd0;
                cap_done   <= 1'b0;
                fifo_flush <= 1'b1;
                vram_req   <= 1'b1;
                vram_addr  <= map_addr(1'b1, 5'd0);
`ifdef PPU_BG_FINE_SCROLL_EN
                first_burst <= 1'b0;
`endif
            end else if (line_end) begin
                state    <= IDLE;
                busy     <= 1'b0;
                cap_done <= 1'b0;
            end else begin
                case (state)
                    TILE_REQ: state <= TILE_CAP;
                    // A stalled capture keeps its byte and waits before issuing the next read.
                    TILE_CAP: begin
                        if (!cap_done) tile_no <= vram_rdata;
                        if (obj_stall) begin
                            cap_done <= 1'b1;
                        end else begin
                            cap_done  <= 1'b0;
                            state     <= LO_REQ;
                            vram_req  <= 1'b1;
                            vram_addr <= data_addr(cap_done ? tile_no : vram_rdata);
                        end
                    end
                    LO_REQ: state <= LO_CAP;
                    LO_CAP: begin
                        if (!cap_done) lo <= vram_rdata;
                        if (obj_stall) begin
                            cap_done <= 1'b1;
                        end else begin
                            cap_done  <= 1'b0;
                            state     <= HI_REQ;
                            vram_req  <= 1'b1;
                            vram_addr <= vram_addr + 13'd1;
                        end
                    end
                    HI_REQ: state <= HI_CAP;
                    HI_CAP: begin
                        hi  <= vram_rdata;
                        pix <= 3'd0;
                        if (can_push) begin
                            fifo_push  <= keep;
                            fifo_color <= keep ? color_of(vram_rdata, lo, 3'd0) : 2'd0;
                            pix        <= 3'd1;
                            state      <= PUSH;
                        end else begin
                            state <= PUSH_WAIT;
                        end
                    end
                    PUSH_WAIT: begin
                        if (can_push) begin
                            fifo_push  <= keep;
                            fifo_color <= keep ? color_of(hi, lo, 3'd0) : 2'd0;
                            pix        <= 3'd1;
                            state      <= PUSH;
                        end
                    end
                    // Occupancy only falls during a burst, so fifo_count is not rechecked here.
                    PUSH: begin
                        if (!obj_stall) begin
                            fifo_push  <= keep;
                            fifo_color <= keep ? color_of(hi, lo, pix) : 2'd0;
                            if (pix == 3'd7) begin
                                pix       <= 3'd0;
                                fetch_x   <= fetch_x + 5'd1;
                                state     <= TILE_REQ;
                                vram_req  <= 1'b1;
                                vram_addr <= map_addr(win_mode, fetch_x + 5'd1);
`ifdef PPU_BG_FINE_SCROLL_EN
                                first_burst <= 1'b0;
`endif
                            end else begin
                                pix <= pix + 3'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// tb/tb_ppu_bg_fetcher.sv - directed self-checking bench for ppu_bg_fetcher
module tb_ppu_bg_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        line_end = 1'b0;
    logic        win_start = 1'b0;
    logic        obj_stall = 1'b0;
    logic [7:0]  ly = 8'd0;
    logic [7:0]  scx = 8'd0;
    logic [7:0]  scy = 8'd0;
    logic [7:0]  win_line = 8'd0;
    logic        bg_map_sel = 1'b0;
    logic        win_map_sel = 1'b0;
    logic        tile_data_sel = 1'b1;
    logic        vram_req;
    logic [12:0] vram_addr;
    logic [7:0]  vram_rdata = 8'd0;
    logic [4:0]  fifo_count = 5'd0;
    logic        fifo_push;
    logic [1:0]  fifo_color;
    logic        fifo_flush;
    logic        busy;

    logic [7:0]  tile_resp = 8'h00;
    logic [7:0]  lo_resp = 8'hF0;
    logic [7:0]  hi_resp = 8'hCC;
    logic [15:0] exp_seq = 16'hF5A0;
    logic [15:0] push_seq = 16'd0;
    int          push_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    ppu_bg_fetcher #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_end(line_end),
        .win_start(win_start), .obj_stall(obj_stall), .ly(ly), .scx(scx), .scy(scy),
        .win_line(win_line), .bg_map_sel(bg_map_sel), .win_map_sel(win_map_sel),
        .tile_data_sel(tile_data_sel), .vram_req(vram_req), .vram_addr(vram_addr),
        .vram_rdata(vram_rdata), .fifo_count(fifo_count), .fifo_push(fifo_push),
        .fifo_color(fifo_color), .fifo_flush(fifo_flush), .busy(busy)
    );

    always #5 clk = ~clk;

    // VRAM model: map region returns the tile number, even/odd data bytes return lo/hi.
    always @(posedge clk) begin
        if (vram_req)
            vram_rdata <= (vram_addr >= 13'h1800) ? tile_resp :
                          (vram_addr[0] ? hi_resp : lo_resp);
    end

    always @(negedge clk) begin
        if (fifo_push) begin
            push_cnt = push_cnt + 1;
            push_seq = {push_seq[13:0], fifo_color};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ls();
        line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
    endtask

    task automatic end_line();
        line_end = 1'b1;
        tick(1);
        line_end = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_req", vram_req, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_push", {fifo_push, fifo_color, fifo_flush}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(2);

        // Basic fetch
        pulse_ls();
        check("ls_flush", fifo_flush, 1);
        check("ls_busy", busy, 1);
        check("map_req", {vram_req, vram_addr}, {1'b1, 13'h1800});
        tick(1);
        check("flush_1cyc", {fifo_flush, vram_req}, 0);
        tick(1);
        check("lo_req", {vram_req, vram_addr}, {1'b1, 13'h0000});
        tick(2);
        check("hi_req", {vram_req, vram_addr}, {1'b1, 13'h0001});
        tick(1);
        check("no_push_5", fifo_push, 0);
        tick(1);
        check("push_6", {fifo_push, fifo_color}, {1'b1, exp_seq[15:14]});
        for (int k = 1; k < 8; k++) begin
            tick(1);
            check($sformatf("color_k%0d", k), {fifo_push, fifo_color},
                  {1'b1, exp_seq[15 - 2 * k -: 2]});
        end
        check("next_map", {vram_req, vram_addr}, {1'b1, 13'h1801});
        end_line();
        check("end_idle", {busy, fifo_push, vram_req}, 0);

        // Signed tile data addressing
        tile_data_sel = 1'b0;
        ly = 8'd3;
        tile_resp = 8'h80;
        pulse_ls();
        tick(2);
        check("s80_lo", vram_addr, 13'h0806);
        tick(2);
        check("s80_hi", vram_addr, 13'h0807);
        tile_resp = 8'h7F;
        pulse_ls();
        tick(2);
        check("s7f_lo", vram_addr, 13'h17F6);
        end_line();

        // Backpressure
        tile_data_sel = 1'b1;
        ly = 8'd0;
        tile_resp = 8'h00;
        fifo_count = 5'd9;
        pulse_ls();
        tick(6);
        check("bp_hold0", fifo_push, 0);
        tick(3);
        check("bp_hold1", fifo_push, 0);
        fifo_count = 5'd8;
        push_cnt = 0;
        tick(1);
        check("bp_start", fifo_push, 1);
        tick(8);
        check("bp_count", push_cnt, 8);
        fifo_count = 5'd0;
        end_line();

        // Scroll wrap
        scx = 8'hF8;
        scy = 8'h10;
        ly = 8'hF8;
        pulse_ls();
        check("wrap_fx0", vram_addr, 13'h183F);
        tick(13);
        check("wrap_fx1", {vram_req, vram_addr}, {1'b1, 13'h1820});
        end_line();
        scx = 8'd0;
        scy = 8'd0;
        ly = 8'd0;

        // Window start mid-burst, replacing the push of k=4
        win_map_sel = 1'b1;
        win_line = 8'h28;
        pulse_ls();
        tick(9);
        win_start = 1'b1;
        tick(1);
        win_start = 1'b0;
        check("win_flush", {fifo_flush, fifo_push}, 2'b10);
        check("win_map", {vram_req, vram_addr}, {1'b1, 13'h1CA0});
        push_cnt = 0;
        tick(1);
        check("win_flush_off", fifo_flush, 0);
        tick(3);
        check("win_no_bg", push_cnt, 0);
        end_line();
        win_map_sel = 1'b0;
        win_line = 8'd0;

        // Stall at k=3
        push_cnt = 0;
        push_seq = 16'd0;
        pulse_ls();
        tick(8);
        obj_stall = 1'b1;
        tick(1);
        check("stall_nopush", fifo_push, 0);
        tick(4);
        check("stall_hold", {fifo_push, vram_req}, 0);
        obj_stall = 1'b0;
        tick(1);
        check("stall_resume", {fifo_push, fifo_color}, {1'b1, exp_seq[9:8]});
        tick(5);
        check("stall_count", push_cnt, 8);
        check("stall_seq", push_seq, exp_seq);
        end_line();

        // Async reset during LO_CAP
        ly = 8'd1;
        pulse_ls();
        tick(3);
        check("pre_rst_addr", vram_addr, 13'h0002);
        #2;
        reset = 1'b1;
        #1;
        check("arst_addr", vram_addr, 0);
        check("arst_outs", {vram_req, fifo_push, fifo_color, fifo_flush, busy}, 0);
        tick(1);
        reset = 1'b0;
        tick(2);
        check("post_rst_idle", {busy, vram_req, fifo_push}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
